dma_bus_arbiter: RTL and testbench

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

---
 rtl/dma_bus_arbiter.sv | 116 +++++++++++
 tb/tb_dma_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// DMA/MPU bus arbiter: stalls the MPU on a read cycle, grants the shared memory
// bus to the DMA for a bounded burst, then guarantees the MPU a minimum gap.
module dma_bus_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MIN_GAP   = 2
) (
    input  logic        CLK,
    input  logic        RES,
    // MPU side
    input  logic        MPU_R_W,
    input  logic [15:0] MPU_AB,
    input  logic [7:0]  MPU_DB_OUT,
    output logic [7:0]  MPU_DB_IN,
    output logic        MPU_RDY,
    // DMA side
    input  logic        DMA_REQ,
    input  logic        DMA_WE,
    input  logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_WDATA,
    input  logic        DMA_LAST,
    output logic        DMA_GNT,
    output logic [7:0]  DMA_RDATA,
    // Memory side
    output logic [15:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_GRANT,
        S_RELEASE
    } state_t;

    localparam logic [8:0] LP_MAX_BURST = 9'(MAX_BURST);
    localparam logic [3:0] LP_MIN_GAP   = 4'(MIN_GAP);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_burst;
    logic [7:0] w_burst_next;
    logic [3:0] r_gap;
    logic [3:0] w_gap_next;
    logic [8:0] w_burst_inc;
    logic       w_dma_owner;

    // 9-bit increment so MAX_BURST=256 is reachable with an 8-bit counter
    assign w_burst_inc = {1'b0, r_burst} + 9'd1;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_burst <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_burst <= w_burst_next;
            r_gap   <= w_gap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_burst_next = r_burst;
        w_gap_next   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (r_gap != '0) begin
                    w_gap_next = r_gap - 4'd1;
                end
                if (DMA_REQ && (r_gap == '0)) begin
                    w_state_next = S_STALL;
                end
            end
            S_STALL: begin
                // An MPU write ignores RDY, so the grant waits for a read cycle
                if (!DMA_REQ) begin
                    w_state_next = S_RELEASE;
                end else if (MPU_R_W) begin
                    w_state_next = S_GRANT;
                    w_burst_next = '0;
                end
            end
            S_GRANT: begin
                if (DMA_REQ) begin
                    w_burst_next = w_burst_inc[7:0];
                    if (DMA_LAST || (w_burst_inc == LP_MAX_BURST)) begin
                        w_state_next = S_RELEASE;
                    end
                end else begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_gap_next   = LP_MIN_GAP;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_dma_owner = (r_state == S_GRANT);

    assign MPU_RDY   = (r_state == S_IDLE);
    assign DMA_GNT   = w_dma_owner;
    assign MEM_ADDR  = w_dma_owner ? DMA_ADDR  : MPU_AB;
    assign MEM_WDATA = w_dma_owner ? DMA_WDATA : MPU_DB_OUT;
    assign MEM_WE    = w_dma_owner ? (DMA_WE & DMA_REQ) : ~MPU_R_W;
    assign MPU_DB_IN = MEM_RDATA;
    assign DMA_RDATA = MEM_RDATA;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: per-cycle expected bus view from a
// phase/quota reference model, checked by an independent negedge monitor.
module tb_dma_bus_arbiter;

    localparam int unsigned TB_MAX_BURST = 4;
    localparam int unsigned TB_MIN_GAP   = 2;

    logic        CLK = 1'b0;
    logic        RES;
    logic        MPU_R_W;
    logic [15:0] MPU_AB;
    logic [7:0]  MPU_DB_OUT;
    logic [7:0]  MPU_DB_IN;
    logic        MPU_RDY;
    logic        DMA_REQ;
    logic        DMA_WE;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_WDATA;
    logic        DMA_LAST;
    logic        DMA_GNT;
    logic [7:0]  DMA_RDATA;
    logic [15:0] MEM_ADDR;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;

    dma_bus_arbiter #(
        .MAX_BURST (TB_MAX_BURST),
        .MIN_GAP   (TB_MIN_GAP)
    ) dut (
        .CLK        (CLK),
        .RES        (RES),
        .MPU_R_W    (MPU_R_W),
        .MPU_AB     (MPU_AB),
        .MPU_DB_OUT (MPU_DB_OUT),
        .MPU_DB_IN  (MPU_DB_IN),
        .MPU_RDY    (MPU_RDY),
        .DMA_REQ    (DMA_REQ),
        .DMA_WE     (DMA_WE),
        .DMA_ADDR   (DMA_ADDR),
        .DMA_WDATA  (DMA_WDATA),
        .DMA_LAST   (DMA_LAST),
        .DMA_GNT    (DMA_GNT),
        .DMA_RDATA  (DMA_RDATA),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WE     (MEM_WE),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Environment memory driven by the DUT
    logic [7:0] mem [0:65535];
    assign MEM_RDATA = mem[MEM_ADDR];
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    end

    typedef struct {
        logic        rdy;
        logic        gnt;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: bus phase plus "transfers left" and "gap cycles left"
    localparam int PH_MPU   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_DMA   = 2;
    localparam int PH_HAND  = 3;
    int          phase;
    int          xfers_left;
    int          gap_left;
    logic [7:0]  mmem [0:65535];
    logic        pend_we;
    logic [15:0] pend_addr;
    logic [7:0]  pend_wd;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        phase      = PH_MPU;
        xfers_left = 0;
        gap_left   = 0;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle just ended
    task automatic model_step();
        if (pend_we) mmem[pend_addr] = pend_wd;
        if (RES) begin
            model_reset();
            return;
        end
        case (phase)
            PH_MPU: begin
                if (DMA_REQ && gap_left == 0) phase = PH_WAIT;
                if (gap_left > 0) gap_left--;
            end
            PH_WAIT: begin
                if (!DMA_REQ) phase = PH_HAND;
                else if (MPU_R_W) begin
                    phase      = PH_DMA;
                    xfers_left = TB_MAX_BURST;
                end
            end
            PH_DMA: begin
                if (!DMA_REQ) phase = PH_HAND;
                else begin
                    xfers_left--;
                    if (DMA_LAST || xfers_left == 0) phase = PH_HAND;
                end
            end
            default: begin
                gap_left = TB_MIN_GAP;
                phase    = PH_MPU;
            end
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.rdy = (phase == PH_MPU);
        e.gnt = (phase == PH_DMA);
        if (phase == PH_DMA) begin
            e.addr  = DMA_ADDR;
            e.wdata = DMA_WDATA;
            e.we    = DMA_WE & DMA_REQ;
        end else begin
            e.addr  = MPU_AB;
            e.wdata = MPU_DB_OUT;
            e.we    = ~MPU_R_W;
        end
        e.rdata   = mmem[e.addr];
        pend_we   = e.we;
        pend_addr = e.addr;
        pend_wd   = e.wdata;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic rw, input logic [15:0] ab,
                         input logic [7:0] dbo, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wd, input logic last);
        @(posedge CLK);
        model_step();
        #1;
        RES        = rst;
        MPU_R_W    = rw;
        MPU_AB     = ab;
        MPU_DB_OUT = dbo;
        DMA_REQ    = req;
        DMA_WE     = we;
        DMA_ADDR   = addr;
        DMA_WDATA  = wd;
        DMA_LAST   = last;
        if (rst) model_reset();
        push_expected();
    endtask

    task automatic mpu_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a bus view, compare it to the oldest entry
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("MPU_RDY",   {15'b0, MPU_RDY},  {15'b0, e.rdy});
            check("DMA_GNT",   {15'b0, DMA_GNT},  {15'b0, e.gnt});
            check("MEM_ADDR",  MEM_ADDR,          e.addr);
            check("MEM_WE",    {15'b0, MEM_WE},   {15'b0, e.we});
            check("MEM_WDATA", {8'b0, MEM_WDATA}, {8'b0, e.wdata});
            check("MPU_DB_IN", {8'b0, MPU_DB_IN}, {8'b0, e.rdata});
            check("DMA_RDATA", {8'b0, DMA_RDATA}, {8'b0, e.rdata});
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]  = 8'h00;
            mmem[a] = 8'h00;
        end
        RES = 1'b1; MPU_R_W = 1'b1; MPU_AB = 16'h0; MPU_DB_OUT = 8'h0;
        DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_ADDR = 16'h0; DMA_WDATA = 8'h0; DMA_LAST = 1'b0;
        pend_we = 1'b0; pend_addr = 16'h0; pend_wd = 8'h0;
        model_reset();

        // Reset held, DMA requesting: must not be accepted
        cycle(1'b1, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0300, 8'h55, 1'b0);
        cycle(1'b1, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0300, 8'h55, 1'b0);
        mpu_idle(2);

        // Three-transfer write burst while the MPU reads $1234
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0200, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0200, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0200, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0201, 8'hBB, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0202, 8'hCC, 1'b1);
        mpu_idle(4);
        check("mem_0200", {8'b0, mem[16'h0200]}, 16'h00AA);
        check("mem_0201", {8'b0, mem[16'h0201]}, 16'h00BB);
        check("mem_0202", {8'b0, mem[16'h0202]}, 16'h00CC);

        // Request during MPU writes, then drop of request in the stall
        cycle(1'b0, 1'b0, 16'h0010, 8'h11, 1'b1, 1'b1, 16'h0400, 8'h77, 1'b0);
        cycle(1'b0, 1'b0, 16'h0011, 8'h22, 1'b1, 1'b1, 16'h0400, 8'h77, 1'b0);
        cycle(1'b0, 1'b0, 16'h0012, 8'h33, 1'b1, 1'b1, 16'h0400, 8'h77, 1'b0);
        cycle(1'b0, 1'b0, 16'h0013, 8'h44, 1'b0, 1'b1, 16'h0400, 8'h77, 1'b0);
        mpu_idle(4);
        check("mem_0400", {8'b0, mem[16'h0400]}, 16'h0000);

        // Reset pulse in the middle of a DMA write grant, then resume
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0500, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0500, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0500, 8'h01, 1'b0);
        cycle(1'b1, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0501, 8'h02, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0502, 8'h03, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 16'h0502, 8'h03, 1'b0);

        // Randomized traffic, including held requests that hit the burst limit
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom_range(0, 63)), 8'($urandom),
                  ($urandom_range(0, 9) < 8), 1'($urandom),
                  16'($urandom_range(0, 63)), 8'($urandom),
                  ($urandom_range(0, 15) == 0));
        end
        mpu_idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
